// File: rtl/input_buffer_pkg.sv
// Shared types and default geometry for the input buffer and its flip-flop RAM.
package input_buffer_pkg;

    localparam int unsigned IBUF_DATA_WIDTH   = 16;
    localparam int unsigned IBUF_ADDR_WIDTH   = 3;
    localparam int unsigned IBUF_DEPTH        = 5;
    localparam int unsigned IBUF_AFULL_THRESH = 4;

    typedef enum logic [1:0] {
        IBUF_EMPTY   = 2'd0,
        IBUF_PARTIAL = 2'd1,
        IBUF_FULL    = 2'd2
    } ibuf_state_t;

endpackage

// File: rtl/ptr_wrap_inc.sv
// Pointer incrementer that wraps from DEPTH-1 back to 0 (DEPTH need not be a power of two).
// Ports:
//   ptr      - current pointer value
//   en       - advance the pointer by one
//   ptr_next - next pointer value (ptr when en=0)
module ptr_wrap_inc #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned DEPTH      = 5
) (
    input  logic [ADDR_WIDTH-1:0] ptr,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] ptr_next
);

    always_comb begin
        ptr_next = ptr;
        if (en) begin
            if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = ptr + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/input_buffer_ctrl.sv
// FIFO sequencer for the input-buffer flip-flop RAM: owns the pointers, occupancy
// and EMPTY/PARTIAL/FULL state, drives the RAM ports and the push/pop handshakes.
// Optional feature macro: INPUT_BUFFER_CTRL_ALMOST_FULL_EN (almost_full_o from count).
// Ports:
//   clk, reset                          - clock (rising edge), async active-low reset
//   in_valid_i/in_data_i/in_ready_o     - upstream push handshake
//   out_valid_o/out_data_o/out_ready_i  - downstream pop handshake (data = RAM read data)
//   ram_waddr_o/ram_wenable_o/ram_wdata_o - RAM write port
//   ram_raddr_o/ram_rdata_i             - RAM combinational read port
//   count_o, full_o, empty_o, almost_full_o - status
module input_buffer_ctrl
    import input_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = IBUF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = IBUF_ADDR_WIDTH,
    parameter int unsigned DEPTH        = IBUF_DEPTH,
    parameter int unsigned AFULL_THRESH = IBUF_AFULL_THRESH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid_i,
    input  logic [DATA_WIDTH-1:0]         in_data_i,
    output logic                          in_ready_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    input  logic                          out_ready_i,
    output logic [ADDR_WIDTH-1:0]         ram_waddr_o,
    output logic                          ram_wenable_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    output logic [ADDR_WIDTH-1:0]         ram_raddr_o,
    input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          almost_full_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    ibuf_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push;
    logic                  pop;

    // Handshakes depend only on registered state (and reset), never on the opposite side.
    assign in_ready_o  = reset & (state_q != IBUF_FULL);
    assign out_valid_o = (state_q != IBUF_EMPTY);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    // RAM ports: write happens on the same edge that advances wr_ptr; read is combinational.
    assign ram_waddr_o   = wr_ptr_q;
    assign ram_wenable_o = push;
    assign ram_wdata_o   = in_data_i;
    assign ram_raddr_o   = rd_ptr_q;
    assign out_data_o    = ram_rdata_i;

    assign count_o = count_q;
    assign full_o  = (state_q == IBUF_FULL);
    assign empty_o = (state_q == IBUF_EMPTY);

    ptr_wrap_inc #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_wr_inc (
        .ptr      (wr_ptr_q),
        .en       (push),
        .ptr_next (wr_ptr_d)
    );

    ptr_wrap_inc #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_rd_inc (
        .ptr      (rd_ptr_q),
        .en       (pop),
        .ptr_next (rd_ptr_d)
    );

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state logic; DEPTH==1 jumps straight between EMPTY and FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IBUF_EMPTY: begin
                if (push) begin
                    state_d = (DEPTH == 1) ? IBUF_FULL : IBUF_PARTIAL;
                end
            end
            IBUF_PARTIAL: begin
                if (push && !pop && (count_q == CW'(DEPTH - 1))) begin
                    state_d = IBUF_FULL;
                end else if (pop && !push && (count_q == CW'(1))) begin
                    state_d = IBUF_EMPTY;
                end
            end
            IBUF_FULL: begin
                if (pop) begin
                    state_d = (DEPTH == 1) ? IBUF_EMPTY : IBUF_PARTIAL;
                end
            end
            default: state_d = IBUF_EMPTY;
        endcase
    end

    // State, pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IBUF_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef INPUT_BUFFER_CTRL_ALMOST_FULL_EN
    // Count is cleared in reset, so this is 0 in reset for any nonzero threshold.
    assign almost_full_o = (count_q >= CW'(AFULL_THRESH));
`else
    logic unused_afull_thresh;
    assign unused_afull_thresh = ^CW'(AFULL_THRESH);
    assign almost_full_o       = 1'b0;
`endif

endmodule

// File: doc/input_buffer_ctrl.md
Name: input_buffer_ctrl

Overview:
- FIFO sequencer for the flip-flop RAM of the input buffer (DEPTH words x DATA_WIDTH).
- Owns write/read pointers, occupancy count and a full/empty state machine.
- Drives the RAM write port (addr/enable/data) and read address.
- Exposes valid/ready handshakes upstream (push) and downstream (pop).
- RAM read is combinational, so pop data is the RAM read data at rd_ptr.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 3, RAM address width; DEPTH must be <= 2**ADDR_WIDTH.
- DEPTH, 5, number of RAM words; need not be a power of two.
- AFULL_THRESH, 4, count at or above which almost_full_o asserts (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  upstream word valid.
- in_data_i  in  DATA_WIDTH  upstream word.
- in_ready_o  out  1  buffer can accept a word.
- out_valid_o  out  1  head word available.
- out_data_o  out  DATA_WIDTH  head word (pass-through of ram_rdata_i).
- out_ready_i  in  1  downstream consumes head.
- ram_waddr_o  out  ADDR_WIDTH  RAM write address (= wr_ptr).
- ram_wenable_o  out  1  RAM write enable.
- ram_wdata_o  out  DATA_WIDTH  RAM write data (= in_data_i).
- ram_raddr_o  out  ADDR_WIDTH  RAM read address (= rd_ptr).
- ram_rdata_i  in  DATA_WIDTH  RAM read data.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- full_o  out  1  state == FULL.
- empty_o  out  1  state == EMPTY.
- almost_full_o  out  1  count_o >= AFULL_THRESH (optional feature).

Behaviour:
- Reset (asynchronous, while reset==0):
  - wr_ptr=0, rd_ptr=0, count=0, state=EMPTY.
  - Outputs: in_ready_o=0, out_valid_o=0, ram_wenable_o=0, empty_o=1, full_o=0, almost_full_o=0.
- Handshakes:
  - push = in_valid_i & in_ready_o.
  - pop = out_valid_o & out_ready_i.
  - in_ready_o = reset & (state != FULL). Registered state only; no combinational dependence on out_ready_i.
  - out_valid_o = (state != EMPTY).
- RAM write: ram_wenable_o = push (combinational). The word is captured by the RAM at the same clk edge that advances wr_ptr.
- Read latency:
  - Zero cycles from head to out_data_o; the head is visible whenever out_valid_o=1.
  - A pushed word is first poppable one cycle after its push edge.
  - There is no bypass when EMPTY.
- Pointers:
  - Advance by 1 on push (wr_ptr) or pop (rd_ptr).
  - Wrap from DEPTH-1 to 0; not a power-of-two modulo.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- State machine (enum EMPTY, PARTIAL, FULL):
  - EMPTY: push -> PARTIAL (or FULL if DEPTH==1). pop is impossible.
  - PARTIAL:
    - push only with count==DEPTH-1 -> FULL.
    - pop only with count==1 -> EMPTY.
    - push and pop -> PARTIAL.
    - otherwise PARTIAL.
  - FULL: pop -> PARTIAL (or EMPTY if DEPTH==1). push is impossible because in_ready_o=0.
- Boundaries:
  - in_valid_i while FULL: ignored, no write, no pointer change.
  - out_ready_i while EMPTY: ignored.
  - Simultaneous push and pop in PARTIAL: both pointers advance and count holds. Write and read addresses differ by construction.
- Reset mid-operation: all contents are logically discarded (pointers reset); RAM contents are not required to be cleared.
- Invariant: count_o == (wr_ptr - rd_ptr) mod DEPTH, except FULL where count_o == DEPTH and wr_ptr == rd_ptr.

Optional Feature:
- Macro: INPUT_BUFFER_CTRL_ALMOST_FULL_EN.
- Defined: almost_full_o = (count_o >= AFULL_THRESH). Computed combinationally from the count register; 0 in reset.
- Undefined: almost_full_o is tied to 0 and AFULL_THRESH is unused. All other behaviour is identical.

Decomposition:
- Package input_buffer_pkg:
  - typedef enum logic [1:0] ibuf_state_t {IBUF_EMPTY, IBUF_PARTIAL, IBUF_FULL}.
  - Default DATA_WIDTH/ADDR_WIDTH/DEPTH constants shared with the RAM.
- Sub-module ptr_wrap_inc:
  - Parameterised ADDR_WIDTH and DEPTH.
  - Inputs: ptr, en. Output: next ptr, with wrap at DEPTH-1.
  - Instantiated twice, for wr_ptr and rd_ptr.

Test Plan:
- Reset release, no traffic -> empty_o=1, in_ready_o=1, out_valid_o=0, count_o=0, ram_wenable_o=0.
- Push 0x1111..0x5555 back-to-back, out_ready_i=0:
  - ram_waddr_o sequence 0,1,2,3,4.
  - Then full_o=1, in_ready_o=0, count_o=5.
  - A 6th in_valid_i produces no write.
- From FULL, pop 5 words -> out_data_o sequence 0x1111..0x5555 in order, ram_raddr_o 0..4, empty_o=1 after the 5th pop.
- Wrap test, 12 continuous words:
  - Push 3, pop 2, then push and pop every cycle for 12 words.
  - Required: pointers wrap 4->0, count_o stays 1, data order preserved.
- Assert reset low mid-stream with count_o=3 -> immediately empty_o=1, in_ready_o=0, out_valid_o=0. After release, the first push writes address 0.
- With INPUT_BUFFER_CTRL_ALMOST_FULL_EN and AFULL_THRESH=4:
  - almost_full_o rises on the cycle count_o becomes 4 and falls when it returns to 3.
  - Without the macro it stays 0.
